// File: rtl/encoder.sv
// Rank-order (time-to-first-spike) image encoder: captures an image and emits every
// pixel ID once over a 4-phase AER link, brightest first, ties to the lowest ID.
module encoder #(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 10,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PIXEL_BITS:0]     image [0:IMAGE_SIZE-1],
  input  logic                    new_image,
  output logic                    image_encoded,
  output logic [IMAGE_SIZE_BITS:0] aerout_addr,
  output logic                    aerout_req,
  input  logic                    aerout_ack
);

  localparam int IW = IMAGE_SIZE_BITS;
  localparam int AW = IMAGE_SIZE_BITS + 1;
  localparam int PW = PIXEL_BITS + 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(IMAGE_SIZE - 1);
  localparam logic [AW-1:0] IMAGE_CNT = AW'(IMAGE_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEARCH,
    S_REQ,
    S_ACKLOW,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [PW-1:0]         img_reg [0:IMAGE_SIZE-1];
  logic [IMAGE_SIZE-1:0] sent_reg;
  logic [AW-1:0]         count_reg;
  logic [IW-1:0]         scan_reg;
  logic [PW-1:0]         best_val_reg;
  logic [IW-1:0]         best_idx_reg;
  logic                  found_reg;
  logic                  ack_s1_reg, ack_s2_reg;
  logic                  req_reg;
  logic [AW-1:0]         addr_reg;
  logic                  enc_reg;

  logic [PW-1:0] cand_val;
  logic          cand_ok;
  logic [PW-1:0] best_val_next;
  logic [IW-1:0] best_idx_next;
  logic          found_next;

  assign aerout_req    = req_reg;
  assign aerout_addr   = addr_reg;
  assign image_encoded = enc_reg;

  // The image copy needs no reset: it is only read after a LOAD rewrites it.
  generate
    for (genvar gi = 0; gi < IMAGE_SIZE; gi++) begin : g_img
      always_ff @(posedge clk) begin
        if (state_reg == S_LOAD) img_reg[gi] <= image[gi];
      end
    end
  endgenerate

  // Running max over unsent pixels; the found flag lets a value-0 pixel win.
  always_comb begin
    cand_val      = img_reg[scan_reg];
    cand_ok       = !sent_reg[scan_reg] && (!found_reg || (cand_val > best_val_reg));
    best_val_next = cand_ok ? cand_val : best_val_reg;
    best_idx_next = cand_ok ? scan_reg : best_idx_reg;
    found_next    = found_reg | cand_ok;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (new_image) state_next = S_LOAD;
      S_LOAD:   state_next = S_SEARCH;
      S_SEARCH: if (scan_reg == LAST_IDX) state_next = S_REQ;
      S_REQ:    if (ack_s2_reg) state_next = S_ACKLOW;
      S_ACKLOW: if (!ack_s2_reg) state_next = (count_reg == IMAGE_CNT) ? S_DONE : S_SEARCH;
      S_DONE:   if (new_image) state_next = S_LOAD;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      ack_s1_reg   <= 1'b0;
      ack_s2_reg   <= 1'b0;
      sent_reg     <= '0;
      count_reg    <= '0;
      scan_reg     <= '0;
      best_val_reg <= '0;
      best_idx_reg <= '0;
      found_reg    <= 1'b0;
      req_reg      <= 1'b0;
      addr_reg     <= '0;
      enc_reg      <= 1'b0;
    end else begin
      ack_s1_reg <= aerout_ack;
      ack_s2_reg <= ack_s1_reg;
      state_reg  <= state_next;
      case (state_reg)
        S_LOAD: begin
          sent_reg  <= '0;
          count_reg <= '0;
          enc_reg   <= 1'b0;
          scan_reg  <= '0;
          found_reg <= 1'b0;
        end
        S_SEARCH: begin
          if (scan_reg == LAST_IDX) begin
            addr_reg  <= AW'(best_idx_next);
            scan_reg  <= '0;
            found_reg <= 1'b0;
          end else begin
            scan_reg     <= scan_reg + IW'(1);
            best_val_reg <= best_val_next;
            best_idx_reg <= best_idx_next;
            found_reg    <= found_next;
          end
        end
        S_REQ: begin
          if (ack_s2_reg) begin
            req_reg                     <= 1'b0;
            sent_reg[addr_reg[IW-1:0]]  <= 1'b1;
            count_reg                   <= count_reg + AW'(1);
          end else begin
            req_reg <= 1'b1;
          end
        end
        S_ACKLOW: begin
          if (!ack_s2_reg && (count_reg == IMAGE_CNT)) enc_reg <= 1'b1;
        end
        S_DONE: begin
          if (new_image) enc_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for the rank-order encoder: directed and random images,
// acting as the AER receiver with random acknowledge delays.
`timescale 1ns/1ps
module tb_encoder;
  localparam int N  = 5;
  localparam int PW = 5;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] image [0:N-1];
  logic          new_image = 1'b0;
  logic          image_encoded;
  logic [AW-1:0] aerout_addr;
  logic          aerout_req;
  logic          aerout_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [PW-1:0] cur_img [0:N-1];
  int exp_seq [N];

  encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .image        (image),
    .new_image    (new_image),
    .image_encoded(image_encoded),
    .aerout_addr  (aerout_addr),
    .aerout_req   (aerout_req),
    .aerout_ack   (aerout_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_img(input int a, input int b, input int c, input int d, input int e);
    cur_img[0] = PW'(a); cur_img[1] = PW'(b); cur_img[2] = PW'(c);
    cur_img[3] = PW'(d); cur_img[4] = PW'(e);
  endtask

  task automatic rand_img();
    for (int i = 0; i < N; i++) cur_img[i] = PW'($urandom_range(0, 10));
  endtask

  // Emission slot of pixel i = number of pixels that must precede it.
  task automatic build_expected();
    for (int i = 0; i < N; i++) begin
      int rank = 0;
      for (int j = 0; j < N; j++)
        if ((cur_img[j] > cur_img[i]) || ((cur_img[j] == cur_img[i]) && (j < i))) rank++;
      exp_seq[rank] = i;
    end
  endtask

  task automatic start_image();
    for (int i = 0; i < N; i++) image[i] = cur_img[i];
    @(negedge clk);
    new_image = 1'b1;
    @(posedge clk);
    #1 new_image = 1'b0;
  endtask

  task automatic run_image(input bit lat_chk, input bit disturb);
    logic [AW-1:0] held_addr;
    int t;
    build_expected();
    start_image();
    if (lat_chk) begin
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk); #1 chk("lat_quiet", aerout_req, 0);
      end
      @(posedge clk); #1 chk("lat_req", aerout_req, 1);
    end
    for (int e = 0; e < N; e++) begin
      t = 0;
      while (!aerout_req && t < 400) begin @(negedge clk); t++; end
      chk("req_rise", aerout_req, 1);
      if (!aerout_req) return;
      held_addr = aerout_addr;
      chk("addr", aerout_addr, exp_seq[e]);
      chk("enc_low", image_encoded, 0);
      if (disturb && e == 1) begin
        for (int i = 0; i < N; i++) image[i] = PW'($urandom_range(0, 10));
        new_image = 1'b1;
        repeat (2) @(negedge clk);
        new_image = 1'b0;
      end
      #($urandom_range(1, 120)) aerout_ack = 1'b1;
      t = 0;
      while (aerout_req && t < 400) begin
        @(negedge clk);
        chk("addr_hold", aerout_addr, held_addr);
        t++;
      end
      chk("req_fall", aerout_req, 0);
      #($urandom_range(1, 120)) aerout_ack = 1'b0;
    end
    t = 0;
    while (!image_encoded && t < 400) begin @(negedge clk); t++; end
    chk("encoded", image_encoded, 1);
    repeat (10) @(negedge clk);
    chk("encoded_held", image_encoded, 1);
    chk("req_idle", aerout_req, 0);
  endtask

  task automatic check_quiet(input string tag);
    bit saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (aerout_req) saw = 1'b1;
    end
    chk(tag, saw, 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < N; i++) image[i] = '0;

    rst_n = 1'b0;
    #100;
    chk("rst_req", aerout_req, 0);
    chk("rst_addr", aerout_addr, 0);
    chk("rst_enc", image_encoded, 0);
    @(negedge clk) rst_n = 1'b1;
    check_quiet("quiet_after_reset");

    set_img(3, 9, 0, 7, 5);    run_image(1'b1, 1'b0);
    set_img(4, 4, 10, 4, 0);   run_image(1'b0, 1'b0);
    set_img(0, 0, 0, 0, 0);    run_image(1'b0, 1'b0);
    set_img(10, 10, 10, 10, 10); run_image(1'b0, 1'b0);
    set_img(6, 2, 8, 2, 6);    run_image(1'b0, 1'b1);
    set_img(1, 2, 3, 4, 5);    run_image(1'b1, 1'b0);

    // Reset while a request is outstanding.
    rand_img();
    start_image();
    t = 0;
    while (!aerout_req && t < 400) begin @(negedge clk); t++; end
    chk("mid_req_rise", aerout_req, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", aerout_req, 0);
    chk("mid_rst_addr", aerout_addr, 0);
    chk("mid_rst_enc", image_encoded, 0);
    @(negedge clk) rst_n = 1'b1;
    check_quiet("quiet_after_mid_reset");
    rand_img(); run_image(1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rand_img();
      run_image(1'b0, (r % 2) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder.md
# encoder

Rank-order (time-to-first-spike) image encoder at the input of the SNN accelerator. It captures a complete image of pixel intensities and emits every pixel ID exactly once over a 4-phase AER output link. IDs are emitted in order of decreasing intensity, so the brightest pixel spikes first. It signals completion to the host interface once the whole image has been encoded.

## Interface
- IMAGE_SIZE, 5 — number of pixels per image.
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE) — pixel-ID index width minus one; address width is IMAGE_SIZE_BITS+1.
- PIXEL_MAX_VALUE, 10 — largest legal pixel intensity.
- PIXEL_BITS, $clog2(PIXEL_MAX_VALUE) — pixel width minus one; each pixel is PIXEL_BITS+1 bits, unsigned.

Ports:
- CLK  in  1  — single system clock, rising edge.
- RST  in  1  — asynchronous reset, active-low.
- IMAGE  in  [PIXEL_BITS:0] x [0:IMAGE_SIZE-1] (unpacked array)  — pixel intensities indexed by pixel ID.
- NEW_IMAGE  in  1  — start request; level-sampled on CLK.
- IMAGE_ENCODED  out  1  — high when every pixel of the current image has been emitted.
- AEROUT_ADDR  out  IMAGE_SIZE_BITS+1  — pixel ID of the current event.
- AEROUT_REQ  out  1  — AER request.
- AEROUT_ACK  in  1  — AER acknowledge; asynchronous to CLK.

## Operation
- Internal state:
  - image register, IMAGE_SIZE x (PIXEL_BITS+1) bits;
  - sent mask, IMAGE_SIZE bits;
  - emitted-count counter;
  - scan index;
  - best-value and best-index registers;
  - 2-flop synchronizer on AEROUT_ACK.
- IDLE: outputs quiet. If NEW_IMAGE=1, go to LOAD.
- LOAD (1 cycle):
  - copy IMAGE into the image register;
  - clear the sent mask and emitted count;
  - clear IMAGE_ENCODED;
  - go to SEARCH.
- SEARCH (IMAGE_SIZE cycles):
  - scan index runs 0..IMAGE_SIZE-1 and tracks the unsent pixel with the largest value;
  - a candidate replaces the best only if strictly greater, so ties resolve to the lowest pixel ID;
  - value-0 pixels are eligible; every pixel is emitted;
  - at the end, latch the best index into AEROUT_ADDR and go to REQ.
- REQ:
  - assert AEROUT_REQ;
  - wait for synchronized ACK=1, then deassert REQ;
  - set the sent bit and increment the count;
  - go to ACKLOW.
- ACKLOW:
  - wait for synchronized ACK=0;
  - if count==IMAGE_SIZE, go to DONE, otherwise go to SEARCH.
- DONE:
  - IMAGE_ENCODED=1, held;
  - NEW_IMAGE=1 clears it and goes to LOAD.
- NEW_IMAGE in any state other than IDLE and DONE is ignored.
- Comparisons are unsigned, at full PIXEL_BITS+1 width; no arithmetic overflow is possible.
- The count register is IMAGE_SIZE_BITS+1 bits wide so it can hold the value IMAGE_SIZE.

## Timing
- Reset values (asynchronous, RST=0):
  - AEROUT_REQ=0, AEROUT_ADDR=0, IMAGE_ENCODED=0;
  - FSM=IDLE, sent mask=0, synchronizer=0.
- Reset mid-operation: AEROUT_REQ drops immediately and the image is discarded. After release, a new NEW_IMAGE is required.
- IMAGE is sampled only in LOAD. It may change freely afterwards.
- First REQ rises 1 (LOAD) + IMAGE_SIZE (SEARCH) + 1 cycles after the edge at which NEW_IMAGE is seen in IDLE.
- AEROUT_ADDR changes only while REQ=0. It is valid at least one cycle before REQ rises and stable until ACK is seen.
- 4-phase handshake:
  - REQ↑ → ACK↑ → REQ↓ → ACK↓;
  - REQ falls 3 cycles after ACK rises (2 synchronizer flops + 1 FSM cycle);
  - the next search starts after ACK low is seen.
- Per-event overhead excluding the receiver's delay: IMAGE_SIZE + 6 cycles.
- IMAGE_ENCODED rises the cycle after the last ACK falling edge is seen.
- Receiver stalls of any length are tolerated: REQ and ADDR are held indefinitely.

## Test plan
- Reset: hold RST=0 for 100 ns → AEROUT_REQ=0, AEROUT_ADDR=0, IMAGE_ENCODED=0. No REQ activity after release without NEW_IMAGE.
- Distinct values: IMAGE={3,9,0,7,5}, one-cycle NEW_IMAGE, receiver acks 100 ns after REQ↑ and releases 100 ns after REQ↓ → ADDR sequence 1,3,4,0,2, then IMAGE_ENCODED=1 and held.
- Ties: IMAGE={4,4,10,4,0} → sequence 2,0,1,3,4.
- Boundary values: IMAGE={0,0,0,0,0} → 0,1,2,3,4; IMAGE={10,10,10,10,10} → 0,1,2,3,4; each ID exactly once.
- Busy and re-start:
  - pulse NEW_IMAGE and change IMAGE mid-encoding → ignored, sequence unchanged, ADDR stable while REQ=1;
  - after IMAGE_ENCODED=1, NEW_IMAGE with {1,2,3,4,5} → IMAGE_ENCODED clears and the sequence is 4,3,2,1,0.
- Reset mid-encoding: assert RST=0 while REQ=1 → REQ falls asynchronously; a new image after release encodes correctly from scratch.
